reaction_test_ctrl: RTL and testbench

Sequencer for one reaction-time trial, clocked on the system clock and paced by the 1 ms tick from the clock divider. On start it waits a pseudo-random foreperiod, then lights the stimulus. It measures milliseconds until the response press and reports the result, or a foul (early press) or a timeout. It also tracks the best valid time for the display and score logic.

---
 rtl/reaction_pkg.sv | 22 ++
 rtl/reaction_lfsr.sv | 23 ++
 rtl/reaction_test_ctrl.sv | 120 ++++++++++++
 tb/tb_reaction_test_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time trial sequencer.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_GO,
        ST_DONE,
        ST_FOUL,
        ST_TIMEOUT
    } state_t;

    localparam int          MS_W_DEFAULT       = 14;
    localparam logic [15:0] LFSR_POLY          = 16'hB400;   // x^16+x^14+x^13+x^11+1, right-shift Galois
    localparam logic [15:0] LFSR_SEED_DEFAULT  = 16'hACE1;
    localparam logic [31:0] BEST_NONE          = '1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_POLY) : (cur >> 1);
    endfunction

endpackage

// File: rtl/reaction_lfsr.sv
// Free-running 16-bit Galois LFSR; exposes its low OUT_BITS bits as the random value.
module reaction_lfsr
    import reaction_pkg::*;
#(
    parameter logic [15:0] SEED     = LFSR_SEED_DEFAULT,
    parameter int          OUT_BITS = 11
) (
    input  logic                clock_undivided,
    input  logic                reset,
    output logic [OUT_BITS-1:0] value
);

    logic [15:0] shift_reg;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_undivided) begin
        if (reset) shift_reg <= SEED;
        else       shift_reg <= lfsr_next(shift_reg);
    end

    assign value = shift_reg[OUT_BITS-1:0];

endmodule

// File: rtl/reaction_test_ctrl.sv
// Single-trial reaction-time sequencer: random foreperiod, stimulus, ms timing,
// foul/timeout detection and best-time tracking.
module reaction_test_ctrl
    import reaction_pkg::*;
#(
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 11,
    parameter int          TIMEOUT_MS   = 9999,
    parameter int          MS_W         = MS_W_DEFAULT,
    parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEFAULT
) (
    input  logic            clock_undivided,
    input  logic            reset,
    input  logic            ms_tick,
    input  logic            start_btn,
    input  logic            resp_btn,
    input  logic            best_clr,
    output logic            stimulus_led,
    output logic            busy,
    output logic [MS_W-1:0] armed_delay_ms,
    output logic [MS_W-1:0] reaction_ms,
    output logic            result_valid,
    output logic            foul,
    output logic            timeout,
    output logic [MS_W-1:0] best_ms
);

    localparam logic [MS_W-1:0] TIMEOUT_VAL = MS_W'(TIMEOUT_MS);
    localparam logic [MS_W-1:0] MIN_VAL     = MS_W'(MIN_DELAY_MS);
    localparam logic [MS_W-1:0] ONE         = MS_W'(1);
    localparam logic [MS_W-1:0] BEST_INIT   = BEST_NONE[MS_W-1:0];

    state_t               state;
    logic [MS_W-1:0]      cnt;
    logic [RAND_BITS-1:0] rand_bits;
    logic [MS_W-1:0]      cnt_inc;
    logic [MS_W-1:0]      armed_last;

    reaction_lfsr #(
        .SEED     (LFSR_SEED),
        .OUT_BITS (RAND_BITS)
    ) u_lfsr (
        .clock_undivided (clock_undivided),
        .reset           (reset),
        .value           (rand_bits)
    );

    assign cnt_inc    = cnt + ONE;
    assign armed_last = armed_delay_ms - ONE;

    always_ff @(posedge clock_undivided) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            stimulus_led   <= 1'b0;
            busy           <= 1'b0;
            armed_delay_ms <= '0;
            reaction_ms    <= '0;
            result_valid   <= 1'b0;
            foul           <= 1'b0;
            timeout        <= 1'b0;
            best_ms        <= BEST_INIT;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE, ST_FOUL, ST_TIMEOUT: begin
                    if (start_btn) begin
                        state          <= ST_ARMED;
                        armed_delay_ms <= MIN_VAL + MS_W'(rand_bits);
                        cnt            <= '0;
                        foul           <= 1'b0;
                        timeout        <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    // An early press beats a final foreperiod tick in the same cycle.
                    if (resp_btn) begin
                        state        <= ST_FOUL;
                        foul         <= 1'b1;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                    end else if (ms_tick) begin
                        if (cnt == armed_last) begin
                            state        <= ST_GO;
                            cnt          <= '0;
                            stimulus_led <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                ST_GO: begin
                    if (resp_btn) begin
                        state        <= ST_DONE;
                        reaction_ms  <= cnt;
                        stimulus_led <= 1'b0;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        if (cnt < best_ms) best_ms <= cnt;
                    end else if (ms_tick) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == TIMEOUT_VAL) begin
                            state        <= ST_TIMEOUT;
                            reaction_ms  <= TIMEOUT_VAL;
                            timeout      <= 1'b1;
                            stimulus_led <= 1'b0;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // Placed last so a clear overrides a same-cycle best-time update.
            if (best_clr) best_ms <= BEST_INIT;
        end
    end

endmodule

// File: tb/tb_reaction_test_ctrl.sv
// Directed bench for reaction_test_ctrl with short delays and a 4-clock ms tick.
module tb_reaction_test_ctrl;

    localparam int          MS_W = 14;
    localparam logic [15:0] SEED = 16'hACE1;

    logic            clock_undivided = 1'b0;
    logic            reset           = 1'b1;
    logic            ms_tick         = 1'b0;
    logic            start_btn       = 1'b0;
    logic            resp_btn        = 1'b0;
    logic            best_clr        = 1'b0;
    logic            stimulus_led;
    logic            busy;
    logic [MS_W-1:0] armed_delay_ms;
    logic [MS_W-1:0] reaction_ms;
    logic            result_valid;
    logic            foul;
    logic            timeout;
    logic [MS_W-1:0] best_ms;

    int          vec_cnt   = 0;
    int          err_cnt   = 0;
    int          tick_div  = 0;
    int          g_ticks   = 0;
    int          go_base   = 0;
    int          rv_cnt    = 0;
    int          cur_delay = 0;
    bit          led_seen  = 1'b0;
    logic [15:0] model_lfsr = 16'h0000;

    reaction_test_ctrl #(
        .MIN_DELAY_MS (5),
        .RAND_BITS    (2),
        .TIMEOUT_MS   (50),
        .MS_W         (MS_W),
        .LFSR_SEED    (SEED)
    ) dut (
        .clock_undivided (clock_undivided),
        .reset           (reset),
        .ms_tick         (ms_tick),
        .start_btn       (start_btn),
        .resp_btn        (resp_btn),
        .best_clr        (best_clr),
        .stimulus_led    (stimulus_led),
        .busy            (busy),
        .armed_delay_ms  (armed_delay_ms),
        .reaction_ms     (reaction_ms),
        .result_valid    (result_valid),
        .foul            (foul),
        .timeout         (timeout),
        .best_ms         (best_ms)
    );

    always #5 clock_undivided = ~clock_undivided;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: taps of x^16+x^14+x^13+x^11+1 land on bits 15, 13, 12, 10.
    function automatic logic [15:0] model_next(input logic [15:0] s);
        logic [15:0] n;
        for (int i = 0; i < 15; i++) n[i] = s[i+1];
        n[15] = s[0];
        n[13] = s[14] ^ s[0];
        n[12] = s[13] ^ s[0];
        n[10] = s[11] ^ s[0];
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic r, input logic c, input logic rs);
        start_btn = s;
        resp_btn  = r;
        best_clr  = c;
        reset     = rs;
        ms_tick   = (tick_div == 3);
        @(posedge clock_undivided);
        model_lfsr = rs ? SEED : model_next(model_lfsr);
        #1;
        if (ms_tick) g_ticks++;
        tick_div = (tick_div + 1) % 4;
        if (result_valid) rv_cnt++;
        if (stimulus_led) led_seen = 1'b1;
        start_btn = 1'b0;
        resp_btn  = 1'b0;
        best_clr  = 1'b0;
        ms_tick   = 1'b0;
    endtask

    task automatic start_trial();
        cur_delay = 5 + int'(model_lfsr[1:0]);
        led_seen  = 1'b0;
        rv_cnt    = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("armed_delay", 32'(armed_delay_ms), 32'(cur_delay));
        check("busy_armed", 32'(busy), 1);
        check("led_armed", 32'(stimulus_led), 0);
    endtask

    task automatic wait_led();
        int  t  = 0;
        bit  ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (g_ticks > 0 && tick_div == 0) t++;
            if (stimulus_led) begin
                ok = 1'b1;
                break;
            end
        end
        check("led_rise", 32'(ok), 1);
        check("led_rise_ticks", 32'(t), 32'(cur_delay));
        go_base = g_ticks;
    endtask

    task automatic go_ticks(input int n);
        int target = g_ticks + n;
        for (int i = 0; i < 1000 && g_ticks < target; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pre_tick();
        for (int i = 0; i < 4 && tick_div != 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic done_trial(input int n, input int exp_best);
        start_trial();
        wait_led();
        go_ticks(n);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("done_reaction", 32'(reaction_ms), 32'(n));
        check("done_valid", 32'(result_valid), 1);
        check("done_best", 32'(best_ms), 32'(exp_best));
        check("done_led", 32'(stimulus_led), 0);
        check("done_busy", 32'(busy), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("done_valid_pulse", 32'(result_valid), 0);
        check("done_valid_count", 32'(rv_cnt), 1);
    endtask

    initial begin
        bit zero_seen = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_led", 32'(stimulus_led), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_armed", 32'(armed_delay_ms), 0);
        check("rst_reaction", 32'(reaction_ms), 0);
        check("rst_valid", 32'(result_valid), 0);
        check("rst_foul", 32'(foul), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_best", 32'(best_ms), 16383);
        check("rst_lfsr", 32'(dut.u_lfsr.shift_reg), 32'(SEED));

        // LFSR sequence against the reference model
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check("lfsr_seq", 32'(dut.u_lfsr.shift_reg), 32'(model_lfsr));
            if (dut.u_lfsr.shift_reg == 16'h0000) zero_seen = 1'b1;
        end
        check("lfsr_nonzero", 32'(zero_seen), 0);

        // Normal trials
        done_trial(37, 37);
        check("delay_range", 32'(armed_delay_ms >= 5 && armed_delay_ms <= 8), 1);
        done_trial(42, 37);

        // Foul: press two ticks into the foreperiod
        start_trial();
        check("start_keeps_reaction", 32'(reaction_ms), 42);
        go_ticks(2);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("foul_flag", 32'(foul), 1);
        check("foul_valid", 32'(result_valid), 1);
        check("foul_busy", 32'(busy), 0);
        check("foul_best", 32'(best_ms), 37);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("foul_led_never", 32'(led_seen), 0);
        check("foul_valid_count", 32'(rv_cnt), 1);

        // Foul: press coincides with the final foreperiod tick
        start_trial();
        check("start_clears_foul", 32'(foul), 0);
        go_ticks(cur_delay - 1);
        pre_tick();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("foul_last_tick", 32'(foul), 1);
        check("foul_last_led", 32'(stimulus_led), 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("foul_last_led_never", 32'(led_seen), 0);

        // Timeout
        start_trial();
        wait_led();
        go_ticks(49);
        check("to_led_before", 32'(stimulus_led), 1);
        check("to_flag_before", 32'(timeout), 0);
        go_ticks(1);
        check("to_led_fall", 32'(stimulus_led), 0);
        check("to_flag", 32'(timeout), 1);
        check("to_reaction", 32'(reaction_ms), 50);
        check("to_valid", 32'(result_valid), 1);
        check("to_best", 32'(best_ms), 37);
        check("to_busy", 32'(busy), 0);

        // Response and tick in the same GO cycle at cnt=10
        start_trial();
        check("start_clears_timeout", 32'(timeout), 0);
        wait_led();
        go_ticks(10);
        pre_tick();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("same_tick_reaction", 32'(reaction_ms), 10);
        check("same_tick_best", 32'(best_ms), 10);

        // Reset in the middle of the foreperiod
        start_trial();
        go_ticks(1);
        rv_cnt = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_led", 32'(stimulus_led), 0);
        check("mid_rst_valid", 32'(result_valid), 0);
        check("mid_rst_reaction", 32'(reaction_ms), 0);
        check("mid_rst_best", 32'(best_ms), 16383);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_rst_idle_busy", 32'(busy), 0);
        check("mid_rst_no_valid", 32'(rv_cnt), 0);

        // Start ignored during GO, then best_clr coinciding with a DONE update
        start_trial();
        wait_led();
        go_ticks(3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("go_start_busy", 32'(busy), 1);
        check("go_start_led", 32'(stimulus_led), 1);
        check("go_start_delay", 32'(armed_delay_ms), 32'(cur_delay));
        go_ticks(2);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("clr_reaction", 32'(reaction_ms), 32'(g_ticks - go_base));
        check("clr_valid", 32'(result_valid), 1);
        check("clr_best", 32'(best_ms), 16383);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
